// File: rtl/iir_pkg.sv
// Shared IIR constants: filter sample width and output FIFO defaults.
// Also holds the occupancy update decode used by the output queue.
package iir_pkg;

    localparam int IIR_NB     = 13;
    localparam int FIFO_NB    = IIR_NB;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // A simultaneous push and pop leaves occupancy unchanged.
    function automatic cnt_op_e cnt_op(input logic push, input logic pop);
        cnt_op_e op;
        op = CNT_HOLD;
        if (push && !pop) op = CNT_INC;
        if (pop && !push) op = CNT_DEC;
        return op;
    endfunction

endpackage

// File: rtl/iir_fifo_mem.sv
// Sample storage for the IIR output queue.
// Synchronous write, asynchronous read, DEPTH x NB, no reset.
module iir_fifo_mem
    import iir_pkg::*;
#(
    parameter int NB    = FIFO_NB,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [NB-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [NB-1:0] rdata
);

    logic [NB-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/iir_out_fifo.sv
// First-word-fall-through output queue between the IIR filter and its sink.
// The filter cannot be stalled, so samples arriving at a full queue are dropped.
module iir_out_fifo
    import iir_pkg::*;
#(
    parameter int NB    = FIFO_NB,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    input  logic [NB-1:0]            DIN,
    input  logic                     VIN,
    output logic [NB-1:0]            DOUT,
    output logic                     VOUT,
    input  logic                     RDY,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic                     OVF,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          ovf;
    logic          push;
    logic          pop;
    logic          drop;
    logic [NB-1:0] rd_data;

    // Flags decode only registered occupancy.
    assign EMPTY = (count == '0);
    assign FULL  = (count == CNT_MAX);
    assign VOUT  = !EMPTY;
    assign COUNT = count;
    assign OVF   = ovf;
    assign DOUT  = EMPTY ? '0 : rd_data;

    assign pop  = VOUT & RDY;
    assign push = VIN & (!FULL | pop);
    assign drop = VIN & FULL & !pop;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case (cnt_op(push, pop))
                CNT_INC: count <= count + (AW+1)'(1);
                CNT_DEC: count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) ovf <= 1'b1;
        end
    end

    iir_fifo_mem #(
        .NB    (NB),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .CLK   (CLK),
        .we    (push & RST_n),
        .waddr (wr_ptr),
        .wdata (DIN),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_iir_out_fifo.sv
// Scoreboard bench for iir_out_fifo: directed cases plus random traffic
// against a queue-level model of the occupancy and drop rules.
module tb_iir_out_fifo;

    localparam int NB    = 13;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic [NB-1:0] DIN = '0;
    logic          VIN = 1'b0;
    logic          RDY = 1'b0;
    logic [NB-1:0] DOUT;
    logic          VOUT;
    logic          FULL;
    logic          EMPTY;
    logic          OVF;
    logic [CW-1:0] COUNT;

    int checks = 0;
    int failures = 0;

    logic [NB-1:0] sb [$];
    int            m_cnt = 0;
    bit            m_ovf = 1'b0;

    iir_out_fifo #(.NB(NB), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .DIN   (DIN),
        .VIN   (VIN),
        .DOUT  (DOUT),
        .VOUT  (VOUT),
        .RDY   (RDY),
        .FULL  (FULL),
        .EMPTY (EMPTY),
        .OVF   (OVF),
        .COUNT (COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, " COUNT"}, 32'(COUNT), 32'(m_cnt));
        chk({tag, " FULL"},  32'(FULL),  32'(m_cnt == DEPTH));
        chk({tag, " EMPTY"}, 32'(EMPTY), 32'(m_cnt == 0));
        chk({tag, " VOUT"},  32'(VOUT),  32'(m_cnt != 0));
        chk({tag, " OVF"},   32'(OVF),   32'(m_ovf));
        if (sb.size() == 0) chk({tag, " DOUT idle"}, 32'(DOUT), 32'(0));
        else                chk({tag, " DOUT head"}, 32'(DOUT), 32'(sb[0]));
    endtask

    // Model decides the outcome of the coming edge, then the edge is applied.
    task automatic step(input bit vin, input logic [NB-1:0] din, input bit rdy,
                        input string tag);
        bit pop;
        bit push;
        pop  = (m_cnt > 0) && rdy;
        push = vin && ((m_cnt < DEPTH) || pop);
        if (push) sb.push_back(din);
        if (vin && !push) m_ovf = 1'b1;
        m_cnt = m_cnt + int'(push) - int'(pop);
        VIN = vin;
        DIN = din;
        RDY = rdy;
        @(posedge CLK);
        #1;
        chk_state(tag);
    endtask

    task automatic do_reset(input bit vin, input bit rdy);
        RST_n = 1'b0;
        VIN   = vin;
        RDY   = rdy;
        DIN   = NB'($urandom);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        m_cnt = 0;
        m_ovf = 1'b0;
        sb.delete();
        chk_state("reset");
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (m_cnt > 0 && n < 4 * DEPTH) begin
            step(1'b0, '0, 1'b1, tag);
            n++;
        end
        chk({tag, " drained"}, 32'(sb.size()), 32'(0));
    endtask

    // Monitor: a pop happens on the next edge whenever VOUT and RDY are high.
    always @(negedge CLK) begin
        if (RST_n && VOUT && RDY) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got %0h expected none", DOUT);
            end else begin
                chk("pop data", 32'(DOUT), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge CLK);
        #1;
        do_reset(1'b1, 1'b1);

        step(1'b1, 13'h0ABC, 1'b0, "first");
        chk("first DOUT", 32'(DOUT), 32'h0ABC);
        drain("first");

        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, NB'(i), 1'b0, "fill");
        chk("fill FULL", 32'(FULL), 32'(1));
        step(1'b1, NB'(9), 1'b0, "overflow");
        chk("overflow OVF", 32'(OVF), 32'(1));
        drain("ovf drain");
        chk("ovf sticky", 32'(OVF), 32'(1));

        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, NB'(i), 1'b0, "fill2");
        step(1'b1, 13'h1FFF, 1'b1, "full push+pop");
        chk("full pp OVF", 32'(OVF), 32'(0));
        drain("fpp drain");

        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b1, NB'($urandom), 1'b1, "stream");
        drain("stream drain");

        for (int i = 1; i <= 9; i++) step(1'b1, NB'(i + 16), 1'b0, "pre5");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "pre5");
        chk("pre5 COUNT", 32'(COUNT), 32'(5));
        do_reset(1'b1, 1'b1);
        step(1'b1, 13'h0155, 1'b0, "post reset");
        drain("post reset");

        do_reset(1'b0, 1'b1);
        step(1'b1, 13'h1000, 1'b1, "neg push");
        step(1'b0, '0, 1'b1, "neg pop");

        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            bit vin;
            bit rdy;
            vin = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 80 : 40));
            rdy = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 40 : 80));
            step(vin, NB'($urandom), rdy, "random");
        end
        drain("random drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iir_out_fifo.md
IIR_OUT_FIFO -- requirements
Module: iir_out_fifo

Interface
REQ-001 SHALL have parameter NB, default 13, sample width in bits (matches filter DOUT).
REQ-002 SHALL have parameter DEPTH, default 8, number of storage entries; power of two, minimum 2.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port DIN  input  NB  signed sample from the filter's DOUT.
REQ-006 SHALL have port VIN  input  1  DIN valid, from the filter's VOUT; no backpressure toward the filter.
REQ-007 SHALL have port DOUT  output  NB  head-of-queue sample to the sink.
REQ-008 SHALL have port VOUT  output  1  DOUT valid (queue non-empty).
REQ-009 SHALL have port RDY  input  1  sink ready; a pop occurs on an edge where VOUT=1 and RDY=1.
REQ-010 SHALL have port FULL  output  1  occupancy equals DEPTH.
REQ-011 SHALL have port EMPTY  output  1  occupancy equals 0.
REQ-012 SHALL have port OVF  output  1  sticky flag: at least one sample dropped since reset.
REQ-013 SHALL have port COUNT  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-014 SHALL implement a first-word-fall-through queue: DOUT shows mem[rd_ptr] whenever VOUT=1.
REQ-015 SHALL drive DOUT to all zeros whenever EMPTY=1.
REQ-016 SHALL derive VOUT=!EMPTY; FULL, EMPTY and COUNT SHALL be registered or decoded from registered state only (no combinational path from VIN or RDY).
REQ-017 SHALL set write latency to one cycle: a sample accepted at edge k appears on DOUT/VOUT after edge k when the queue was empty.
REQ-018 SHALL define push as VIN=1 and (FULL=0 or pop at the same edge); on push, mem[wr_ptr]<=DIN and wr_ptr advances.
REQ-019 SHALL advance rd_ptr on pop; data of a popped entry is not cleared.
REQ-020 SHALL update COUNT as follows: push only +1; pop only -1; both or neither unchanged.
REQ-021 SHALL accept the write when full and a pop occurs at the same edge; COUNT stays DEPTH and OVF is unchanged.
REQ-022 SHALL handle a push while empty at the same edge as a high RDY as write only, since VOUT=0 means no pop.
REQ-023 SHALL drop DIN when VIN=1, FULL=1 and no pop: storage and pointers unchanged, OVF<=1.
REQ-024 SHALL keep OVF set until reset, regardless of later drains.
REQ-025 SHALL wrap pointers from DEPTH-1 to 0 (modulo DEPTH); occupancy is tracked by COUNT, not pointer comparison alone.
REQ-026 SHALL ignore RDY when EMPTY=1, and SHALL ignore DIN when VIN=0.
REQ-027 SHALL pass samples unmodified (bit-exact, no saturation or sign change); order strictly FIFO.

Reset
REQ-028 SHALL, on an edge with RST_n=0, set wr_ptr=0, rd_ptr=0, COUNT=0, OVF=0, giving EMPTY=1, FULL=0, VOUT=0, DOUT=0.
REQ-029 SHALL let reset override simultaneous VIN/RDY: no push or pop is performed on a reset edge.
REQ-030 SHALL discard queued samples when reset is asserted mid-operation; storage array contents need not be reset.

Structure
REQ-031 SHALL take NB and the default DEPTH from the shared IIR package, alongside the filter's sample width constant.
REQ-032 SHALL place the storage array in one sub-module, iir_fifo_mem (synchronous write, asynchronous read, DEPTH x NB); pointers, count and flags remain in iir_out_fifo.

Verification
REQ-033 Bench SHALL cover: reset, then VIN=1 with DIN=0x0ABC and RDY=0 -> after one edge VOUT=1, DOUT=0x0ABC, COUNT=1, EMPTY=0.
REQ-034 Bench SHALL cover: 8 pushes of values 1..8 with RDY=0 -> FULL=1, COUNT=8; 9th push of value 9 -> OVF=1, COUNT=8; then RDY=1 drains exactly 1..8 in order and EMPTY=1.
REQ-035 Bench SHALL cover: full queue, VIN=1 with DIN=0x1FFF and RDY=1 on the same edge -> COUNT stays 8, OVF stays 0, and 0x1FFF is the last value drained.
REQ-036 Bench SHALL cover: continuous VIN=1 and RDY=1 over 20 samples, crossing the pointer wrap -> COUNT stays at 1 after the first edge and output equals input delayed by one cycle.
REQ-037 Bench SHALL cover: RST_n=0 for one edge with COUNT=5 and OVF=1 -> COUNT=0, OVF=0, VOUT=0, DOUT=0; the next push is read back correctly.
REQ-038 Bench SHALL cover: empty queue, RDY=1 held, one push of 0x1000 (negative) -> popped on the following edge, DOUT=0x1000 exactly, COUNT returns to 0.
